conv_input_interface: RTL and testbench

// - Feature-map line buffer between feature memory and the conv kernel array; executes the conv layer controller's commands.
// - PRELOAD fills K image rows.
// - SHIFT streams one KxK window column by column.
// - LOAD replaces the oldest row with the next image row.
// - Returns a one-cycle ack per completed command on input_interface_ack.

---
 rtl/conv_input_interface.sv | 228 ++++++++++++++++++++++
 tb/tb_conv_input_interface.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/conv_input_interface.sv
// ----------------------------------------------------------------------------
// conv_input_interface
//
// Feature-map line buffer that sits between the feature memory and the conv
// kernel array. It holds K image rows and runs the commands issued by the
// conv layer controller:
//   PRELOAD : fetch K full image rows from address 0 into the buffer
//   SHIFT   : stream one KxK window, one column per cycle (oldest row first)
//   LOAD    : replace the oldest buffered row with the next image row
// Each completed command is answered with a one-cycle ack code.
//
// Ports
//   clk                  in   1       clock, rising edge
//   rst_n                in   1       asynchronous active-low reset
//   input_interface_cmd  in   2       0 IDLE, 1 PRELOAD, 2 SHIFT, 3 LOAD (pulse)
//   input_interface_ack  out  2       0 none, 1 PRELOAD_FIN, 2 SHIFT_FIN, 3 LOAD_FIN
//   mem_rd_en            out  1       feature memory read strobe
//   mem_addr             out  ADDR_W  row-major read address
//   mem_rdata            in   DW      read data, one cycle after mem_rd_en
//   col_data             out  K*DW    window column, logical row 0 in the LSBs
//   col_valid            out  1       col_data valid
//   busy                 out  1       a command is in progress
// ----------------------------------------------------------------------------
module conv_input_interface #(
    parameter int DW     = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        input_interface_cmd,
    output logic [1:0]        input_interface_ack,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DW-1:0]     mem_rdata,
    output logic [K*DW-1:0]   col_data,
    output logic              col_valid,
    output logic              busy
);

    localparam int RW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int NW = $clog2(K * IMG_W + 1);

    localparam logic [1:0] CMD_IDLE    = 2'd0;
    localparam logic [1:0] CMD_PRELOAD = 2'd1;
    localparam logic [1:0] CMD_SHIFT   = 2'd2;
    localparam logic [1:0] CMD_LOAD    = 2'd3;

    localparam logic [NW-1:0]     N_PRE         = NW'(K * IMG_W);
    localparam logic [NW-1:0]     N_LD          = NW'(IMG_W);
    localparam logic [ADDR_W-1:0] ADDR_LAST     = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [CW-1:0]     COL_LAST      = CW'(IMG_W - 1);
    localparam logic [CW-1:0]     COL_LAST_BASE = CW'(IMG_W - K);
    localparam logic [RW-1:0]     ROW_LAST      = RW'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_STREAM = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_op;          // command being executed; doubles as ack code
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [NW-1:0]       r_rd_cnt;      // reads issued in the current fetch
    logic                r_rd_d1;       // read issued last cycle -> data valid now
    logic [RW-1:0]       r_wr_row;      // physical row receiving fetched data
    logic [CW-1:0]       r_wr_col;
    logic [RW-1:0]       r_top_row;     // physical row holding logical row 0
    logic [CW-1:0]       r_col_base;    // leftmost column of the next window
    logic [RW-1:0]       r_sh_cnt;      // column currently presented, 0..K-1
    logic [K*DW-1:0]     r_col_data;
    logic                r_col_valid;

    logic [DW-1:0]       r_buf [0:K-1][0:IMG_W-1];

    logic [NW-1:0]       w_n;
    logic                w_mem_rd_en;
    logic [CW-1:0]       w_sel_col;
    logic [K*DW-1:0]     w_col_word;

    assign w_n         = (r_op == CMD_PRELOAD) ? N_PRE : N_LD;
    assign w_mem_rd_en = (r_state == S_FETCH) && (r_rd_cnt < w_n);

    // Column to load into col_data at the coming edge: the first window
    // column when a SHIFT is accepted, otherwise the one after the current.
    assign w_sel_col = (r_state == S_STREAM) ?
                       (r_col_base + CW'(r_sh_cnt) + CW'(1)) : r_col_base;

    // Gather one window column, mapping logical row gi onto its physical row.
    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_row
            logic [RW:0]   w_sum;
            logic [RW-1:0] w_phys;
            assign w_sum  = {1'b0, r_top_row} + (RW+1)'(gi);
            assign w_phys = (w_sum >= (RW+1)'(K)) ? RW'(w_sum - (RW+1)'(K))
                                                  : RW'(w_sum);
            assign w_col_word[gi*DW +: DW] = r_buf[w_phys][w_sel_col];
        end
    endgenerate

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                case (input_interface_cmd)
                    CMD_PRELOAD,
                    CMD_LOAD:  w_state_next = S_FETCH;
                    CMD_SHIFT: w_state_next = S_STREAM;
                    default:   w_state_next = S_IDLE;
                endcase
            end
            // The last read's data lands in the cycle where the count is full.
            S_FETCH:  if (r_rd_cnt == w_n) w_state_next = S_ACK;
            S_STREAM: if (r_sh_cnt == ROW_LAST) w_state_next = S_ACK;
            S_ACK:    w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= CMD_IDLE;
            r_rd_addr   <= '0;
            r_rd_cnt    <= '0;
            r_rd_d1     <= 1'b0;
            r_wr_row    <= '0;
            r_wr_col    <= '0;
            r_top_row   <= '0;
            r_col_base  <= '0;
            r_sh_cnt    <= '0;
            r_col_data  <= '0;
            r_col_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rd_d1 <= w_mem_rd_en;

            if (r_rd_d1) begin
                if (r_wr_col == COL_LAST) begin
                    r_wr_col <= '0;
                    r_wr_row <= (r_wr_row == ROW_LAST) ? '0 : r_wr_row + RW'(1);
                end else begin
                    r_wr_col <= r_wr_col + CW'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    case (input_interface_cmd)
                        CMD_PRELOAD: begin
                            r_op       <= CMD_PRELOAD;
                            r_rd_addr  <= '0;
                            r_rd_cnt   <= '0;
                            r_top_row  <= '0;
                            r_col_base <= '0;
                            r_wr_row   <= '0;
                            r_wr_col   <= '0;
                        end
                        CMD_LOAD: begin
                            r_op       <= CMD_LOAD;
                            r_rd_cnt   <= '0;
                            r_col_base <= '0;
                            r_wr_row   <= r_top_row;  // overwrite the oldest row
                            r_wr_col   <= '0;
                        end
                        CMD_SHIFT: begin
                            r_op        <= CMD_SHIFT;
                            r_col_data  <= w_col_word;
                            r_col_valid <= 1'b1;
                            r_sh_cnt    <= '0;
                        end
                        default: ;
                    endcase
                end
                S_FETCH: begin
                    if (w_mem_rd_en) begin
                        r_rd_cnt  <= r_rd_cnt + NW'(1);
                        r_rd_addr <= (r_rd_addr == ADDR_LAST) ? '0
                                                              : r_rd_addr + ADDR_W'(1);
                    end
                end
                S_STREAM: begin
                    if (r_sh_cnt == ROW_LAST) begin
                        r_col_valid <= 1'b0;      // col_data keeps the last column
                    end else begin
                        r_col_data <= w_col_word;
                        r_sh_cnt   <= r_sh_cnt + RW'(1);
                    end
                end
                S_ACK: begin
                    if (r_op == CMD_SHIFT) begin
                        r_col_base <= (r_col_base == COL_LAST_BASE) ? '0
                                                                    : r_col_base + CW'(1);
                    end
                    if (r_op == CMD_LOAD) begin
                        // The freshly loaded row becomes logical row K-1.
                        r_top_row <= (r_top_row == ROW_LAST) ? '0 : r_top_row + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Line buffer storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (r_rd_d1) begin
            r_buf[r_wr_row][r_wr_col] <= mem_rdata;
        end
    end

    assign mem_rd_en           = w_mem_rd_en;
    assign mem_addr            = r_rd_addr;
    assign col_data            = r_col_data;
    assign col_valid           = r_col_valid;
    assign busy                = (r_state != S_IDLE);
    assign input_interface_ack = (r_state == S_ACK) ? r_op : 2'd0;

endmodule

// File: tb/tb_conv_input_interface.sv
// ----------------------------------------------------------------------------
// tb_conv_input_interface
//
// Directed bench for conv_input_interface with default parameters. The
// feature memory model returns mem[a] = a one cycle after a read strobe.
// Outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_conv_input_interface;

    localparam int DW     = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int K      = 3;
    localparam int ADDR_W = 6;

    localparam logic [1:0] C_IDLE    = 2'd0;
    localparam logic [1:0] C_PRELOAD = 2'd1;
    localparam logic [1:0] C_SHIFT   = 2'd2;
    localparam logic [1:0] C_LOAD    = 2'd3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        cmd = 2'd0;
    logic [1:0]        ack;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DW-1:0]     mem_rdata = '0;
    logic [K*DW-1:0]   col_data;
    logic              col_valid;
    logic              busy;

    int errs   = 0;
    int checks = 0;

    conv_input_interface #(
        .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .input_interface_cmd (cmd),
        .input_interface_ack (ack),
        .mem_rd_en           (mem_rd_en),
        .mem_addr            (mem_addr),
        .mem_rdata           (mem_rdata),
        .col_data            (col_data),
        .col_valid           (col_valid),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    // Feature memory: mem[a] = a, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= DW'(mem_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Window column c of image rows r0 (oldest), r1, r2: pixel = row*IMG_W + col.
    function automatic logic [K*DW-1:0] colw(input int r0, input int r1, input int r2, input int c);
        return {8'(r2 * IMG_W + c), 8'(r1 * IMG_W + c), 8'(r0 * IMG_W + c)};
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_valid"}, col_valid, 0);
    endtask

    // PRELOAD or LOAD: N reads from 'start', ack two cycles after the last read.
    // 'inj' >= 0 drives a SHIFT pulse in that read cycle, which must be ignored.
    task automatic do_fetch(input logic [1:0] c, input int start, input int n, input int inj);
        cmd = c;
        tick();
        cmd = C_IDLE;
        for (int i = 0; i < n; i++) begin
            chk("fetch_rd_en", mem_rd_en, 1);
            chk("fetch_addr", mem_addr, (start + i) % (IMG_W * IMG_H));
            chk("fetch_busy", busy, 1);
            chk("fetch_ack_early", ack, 0);
            chk("fetch_valid", col_valid, 0);
            cmd = (i == inj) ? C_SHIFT : C_IDLE;
            tick();
        end
        cmd = C_IDLE;
        chk("fetch_rd_en_off", mem_rd_en, 0);
        chk("fetch_ack_early", ack, 0);
        tick();
        chk("fetch_ack", ack, c);
        chk("fetch_ack_busy", busy, 1);
        tick();
        chk("fetch_ack_width", ack, 0);
        chk("fetch_done_busy", busy, 0);
        chk("fetch_done_valid", col_valid, 0);
        $display("fetch cmd=%0d start=%0d n=%0d inj=%0d errors=%0d", c, start, n, inj, errs);
    endtask

    // SHIFT: K valid columns cb..cb+K-1 of rows r0,r1,r2, then SHIFT_FIN.
    task automatic do_shift(input int r0, input int r1, input int r2, input int cb);
        cmd = C_SHIFT;
        tick();
        cmd = C_IDLE;
        for (int j = 0; j < K; j++) begin
            chk("shift_valid", col_valid, 1);
            chk("shift_data", col_data, colw(r0, r1, r2, cb + j));
            chk("shift_ack_early", ack, 0);
            chk("shift_busy", busy, 1);
            tick();
        end
        chk("shift_valid_off", col_valid, 0);
        chk("shift_ack", ack, C_SHIFT);
        chk("shift_hold", col_data, colw(r0, r1, r2, cb + K - 1));
        tick();
        chk("shift_ack_width", ack, 0);
        chk("shift_done_busy", busy, 0);
        $display("shift rows=%0d,%0d,%0d col_base=%0d errors=%0d", r0, r1, r2, cb, errs);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_ack", ack, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_col_data", col_data, 0);
        chk("rst_valid", col_valid, 0);
        chk("rst_busy", busy, 0);
        $display("reset released");
        rst_n = 1'b1;
        tick();

        // CMD_IDLE is a no-op
        cmd = C_IDLE;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_quiet("idle");
        end
        $display("idle cycles done errors=%0d", errs);

        // Preload rows 0..2, then walk the window across the row and wrap.
        do_fetch(C_PRELOAD, 0, K * IMG_W, -1);
        for (int s = 0; s < 6; s++) do_shift(0, 1, 2, s);
        do_shift(0, 1, 2, 0);

        // LOAD brings in row 3 as the newest logical row and clears col_base.
        do_fetch(C_LOAD, 24, IMG_W, -1);
        do_shift(1, 2, 3, 0);

        // SHIFT during a PRELOAD fetch is ignored.
        do_fetch(C_PRELOAD, 0, K * IMG_W, 5);
        do_shift(0, 1, 2, 0);

        // Six LOADs: rows 3..7, then the address wraps and row 0 is read.
        for (int l = 0; l < 6; l++) do_fetch(C_LOAD, (24 + 8 * l) % 64, IMG_W, -1);
        do_shift(6, 7, 0, 0);
        do_fetch(C_PRELOAD, 0, K * IMG_W, -1);

        // Reset in the middle of a PRELOAD.
        cmd = C_PRELOAD;
        tick();
        cmd = C_IDLE;
        repeat (4) tick();
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_rd_en", mem_rd_en, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_col_data", col_data, 0);
        chk("mid_rst_valid", col_valid, 0);
        chk("mid_rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk_quiet("post_rst");
        end
        $display("mid-command reset done errors=%0d", errs);
        do_fetch(C_PRELOAD, 0, K * IMG_W, -1);
        do_shift(0, 1, 2, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
